// File: rtl/cd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : cd_spi_slave
// Brief    : SPI mode-0 slave that bridges a host MCU onto the CDBUS CSR bus.
// Revision : 1.0 - initial release
// ============================================================================
module cd_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_nss,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        chip_select,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    input  logic [31:0] csr_readdata,
    output logic        csr_write,
    output logic [31:0] csr_writedata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_pipe, mosi_pipe, nss_pipe;
    logic        sclk_s, mosi_s, nss_s;
    logic        sclk_prev, nss_prev;
    logic        rise_q, fall_q, mosi_q;
    logic        nss_fall, nss_rise;
    logic [4:0]  bit_cnt;
    logic [6:0]  byte_sh;
    logic [7:0]  new_byte;
    logic [23:0] wr_word;
    logic [31:0] tx_word;
    logic        cmd_done, word_done;

    assign sclk_s      = sclk_pipe[SYNC_STAGES-1];
    assign mosi_s      = mosi_pipe[SYNC_STAGES-1];
    assign nss_s       = nss_pipe[SYNC_STAGES-1];
    assign nss_fall    = nss_prev & ~nss_s;
    assign nss_rise    = ~nss_prev & nss_s;
    assign new_byte    = {byte_sh, mosi_q};
    assign spi_miso_oe = chip_select;

    // sclk edges are registered together with mosi so the sampled bit lines up with its edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_pipe <= '0;
            mosi_pipe <= '0;
            nss_pipe  <= '1;
            sclk_prev <= 1'b0;
            nss_prev  <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi_sclk};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            nss_pipe  <= {nss_pipe[SYNC_STAGES-2:0], spi_nss};
            sclk_prev <= sclk_s;
            nss_prev  <= nss_s;
            rise_q    <= sclk_s & ~sclk_prev;
            fall_q    <= ~sclk_s & sclk_prev;
            mosi_q    <= mosi_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Deselect overrides everything, including a word completing in the same cycle
    always_comb begin
        next_state = state;
        cmd_done   = 1'b0;
        word_done  = 1'b0;
        if (nss_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (nss_fall) next_state = CMD;
                CMD: begin
                    if (rise_q && bit_cnt == 5'd7) begin
                        cmd_done   = 1'b1;
                        next_state = new_byte[7] ? WR : RD;
                    end
                end
                WR:      word_done = rise_q && (bit_cnt == 5'd31);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chip_select   <= 1'b0;
            spi_miso      <= 1'b0;
            csr_address   <= 4'd0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= 32'd0;
            bit_cnt       <= 5'd0;
            byte_sh       <= 7'd0;
            wr_word       <= 24'd0;
            tx_word       <= 32'd0;
        end else begin
            chip_select <= ~nss_s;
            csr_read    <= 1'b0;
            csr_write   <= 1'b0;
            if (nss_rise) begin
                spi_miso <= 1'b0;
                bit_cnt  <= 5'd0;
                byte_sh  <= 7'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (nss_fall) begin
                            bit_cnt <= 5'd0;
                            byte_sh <= 7'd0;
                        end
                    end
                    CMD: begin
                        if (rise_q) begin
                            byte_sh <= new_byte[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (cmd_done) begin
                            csr_address <= new_byte[3:0];
                            csr_read    <= ~new_byte[7];
                            bit_cnt     <= 5'd0;
                        end
                    end
                    WR: begin
                        if (rise_q) begin
                            byte_sh <= new_byte[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt[2:0] == 3'd7) begin
                                case (bit_cnt[4:3])
                                    2'd0:    wr_word[7:0]   <= new_byte;
                                    2'd1:    wr_word[15:8]  <= new_byte;
                                    2'd2:    wr_word[23:16] <= new_byte;
                                    default: ;
                                endcase
                            end
                        end
                        if (word_done) begin
                            csr_writedata <= {new_byte, wr_word};
                            csr_write     <= 1'b1;
                        end
                    end
                    default: begin
                        // bit_cnt names the next bit the host samples: byte bit_cnt[4:3], MSB first
                        if (csr_read) begin
                            tx_word  <= csr_readdata;
                            spi_miso <= csr_readdata[7];
                        end else if (fall_q) begin
                            spi_miso <= tx_word[{bit_cnt[4:3], ~bit_cnt[2:0]}];
                        end
                        if (rise_q) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) csr_read <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_cd_spi_slave
// Brief    : Scoreboard bench driving SPI mode-0 host transactions into cd_spi_slave.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cd_spi_slave;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_nss = 1'b1;
    logic        spi_miso, spi_miso_oe, chip_select;
    logic [3:0]  csr_address;
    logic        csr_read, csr_write;
    logic [31:0] csr_readdata;
    logic [31:0] csr_writedata;

    logic [31:0] rd_word = 32'hDEAD_BEEF;
    logic        pop_next = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [35:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_rx[$];
    logic [31:0] rd_src[$];

    assign csr_readdata = rd_word;

    always #5 clk = ~clk;

    cd_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_nss       (spi_nss),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .chip_select   (chip_select),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_readdata  (csr_readdata),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    // CSR model: word at the queue head is presented until the cycle after a read strobe
    always @(negedge clk) begin
        if (pop_next && rd_src.size() > 0) void'(rd_src.pop_front());
        pop_next = csr_read;
        rd_word  = (rd_src.size() > 0) ? rd_src[0] : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (csr_write && csr_read) unexpected("rd_wr_overlap", 64'd1);
        if (csr_write) begin
            if (exp_wr.size() == 0) unexpected("unexpected_write", {csr_address, csr_writedata});
            else check("csr_write", {csr_address, csr_writedata}, exp_wr.pop_front());
        end
        if (csr_read) begin
            if (exp_rd.size() == 0) unexpected("unexpected_read", csr_address);
            else check("csr_read_addr", csr_address, exp_rd.pop_front());
        end
    end

    always @(posedge clk) begin
        if (rx_valid) begin
            if (exp_rx.size() == 0) unexpected("unexpected_rx", rx_byte);
            else check("miso_byte", rx_byte, exp_rx.pop_front());
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, input bit post);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            wait_clk(HALF);
            r = {r[6:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        if (post) begin
            rx_byte  = r;
            rx_valid = 1'b1;
            wait_clk(1);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit post);
        for (int b = 0; b < 4; b++) spi_bits(w[8*b +: 8], 8, post);
    endtask

    task automatic push_rx_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_rx.push_back(w[8*b +: 8]);
    endtask

    task automatic spi_start();
        spi_nss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_stop();
        wait_clk(HALF);
        spi_nss = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {spi_miso, spi_miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata},
              64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_clk(3);
        check_idle_outputs("reset_outputs");
        reset_n = 1'b1;
        wait_clk(5);

        // Single-word write to address 1
        exp_wr.push_back({4'h1, 32'h0000_000A});
        spi_start();
        check("chip_select_active", {chip_select, spi_miso_oe}, 2'b11);
        spi_bits(8'h81, 8, 1'b0);
        send_word(32'h0000_000A, 1'b0);
        spi_stop();

        // Single-word read from address 0, one prefetch
        rd_src.push_back(32'h0000_000F);
        rd_src.push_back(32'h1234_5678);
        exp_rd.push_back(4'h0);
        exp_rd.push_back(4'h0);
        push_rx_word(32'h0000_000F);
        spi_start();
        spi_bits(8'h00, 8, 1'b0);
        send_word(32'h0, 1'b1);
        spi_stop();
        check("miso_idle_after_read", {spi_miso, chip_select}, 2'b00);

        // TX FIFO burst: two words to address 0xC
        exp_wr.push_back({4'hC, 32'h0403_0201});
        exp_wr.push_back({4'hC, 32'h0807_0605});
        spi_start();
        spi_bits(8'h8C, 8, 1'b0);
        send_word(32'h0403_0201, 1'b0);
        send_word(32'h0807_0605, 1'b0);
        spi_stop();

        // RX burst read: two words plus a prefetch
        rd_src.push_back(32'hA1B2_C3D4);
        rd_src.push_back(32'h5566_7788);
        rd_src.push_back(32'h99AA_BBCC);
        for (int k = 0; k < 3; k++) exp_rd.push_back(4'hB);
        push_rx_word(32'hA1B2_C3D4);
        push_rx_word(32'h5566_7788);
        spi_start();
        spi_bits(8'h0B, 8, 1'b0);
        send_word(32'h0, 1'b1);
        send_word(32'h0, 1'b1);
        spi_stop();

        // Abort after two data bytes: no write may appear
        spi_start();
        spi_bits(8'h82, 8, 1'b0);
        spi_bits(8'h11, 8, 1'b0);
        spi_bits(8'h22, 8, 1'b0);
        spi_stop();
        check("abort_deselected", {chip_select, spi_miso_oe, spi_miso, csr_write}, 4'b0000);

        exp_wr.push_back({4'h3, 32'hEFBE_ADDE});
        spi_start();
        spi_bits(8'h83, 8, 1'b0);
        send_word(32'hEFBE_ADDE, 1'b0);
        spi_stop();

        // Reset after 20 bits of a write transaction
        spi_start();
        spi_bits(8'h85, 8, 1'b0);
        spi_bits(8'h12, 8, 1'b0);
        spi_bits(8'h34, 4, 1'b0);
        wait_clk(2);
        reset_n = 1'b0;
        wait_clk(2);
        check_idle_outputs("reset_mid_write");
        spi_nss = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(5);

        exp_wr.push_back({4'h7, 32'h1234_5678});
        spi_start();
        spi_bits(8'h87, 8, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        spi_stop();

        wait_clk(20);
        check("writes_outstanding", exp_wr.size(), 0);
        check("reads_outstanding", exp_rd.size(), 0);
        check("rx_outstanding", exp_rx.size(), 0);
        check("readdata_left", rd_src.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
